// File: rtl/mem_scan_reader.sv
// mem_scan_reader: reads count words from base_addr through a 2-entry buffer and streams them out.
// Optional trailing checksum beat when MEM_SCAN_CHECKSUM_EN is defined.
module mem_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
`ifdef MEM_SCAN_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, READ, DRAIN, SUM} state_t;
  logic [DATA_W-1:0] acc;
`else
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif
  state_t state, state_n;
  logic [ADDR_W:0] rem;
  logic pend, pend_last, l0, l1;
  logic [ADDR_W-1:0] pend_addr, a0, a1;
  logic [DATA_W-1:0] d0, d1;
  logic [1:0] occ;
  logic hv, pop, head_l, lx, fin, zstart, done_n, busy_n, shift, push;
  // The in-flight word is presented directly on the output so the first beat
  // appears the cycle its data returns; it only lands in the buffer if not taken.
  always_comb begin
    hv = occ != 2'd0 || pend;
    pop = hv && out_ready;
    head_l = occ != 2'd0 ? l0 : pend_last;
    lx = pop && head_l;
    shift = pop && occ != 2'd0;
    push = pend && !(pop && occ == 2'd0);
    mem_rd_en = state == READ && (occ == 2'd0 || (occ == 2'd1 && (!pend || pop)));
    out_valid = hv;
    out_addr = hv ? (occ != 2'd0 ? a0 : pend_addr) : '0;
    out_data = hv ? (occ != 2'd0 ? d0 : mem_rdata) : '0;
`ifdef MEM_SCAN_CHECKSUM_EN
    out_last = 1'b0;
    if (state == SUM) begin
      out_valid = 1'b1;
      out_addr = '0;
      out_data = acc;
      out_last = 1'b1;
    end
    fin = state == SUM && out_ready;
`else
    out_last = hv && head_l;
    fin = state == DRAIN && lx;
`endif
    zstart = state == IDLE && start && count == '0;
    state_n = state;
    if (state == IDLE && start && count != '0) state_n = READ;
    if (state == READ && mem_rd_en && rem == (ADDR_W+1)'(1)) state_n = DRAIN;
`ifdef MEM_SCAN_CHECKSUM_EN
    if (state == DRAIN && lx) state_n = SUM;
    if (state == SUM && out_ready) state_n = IDLE;
`else
    if (state == DRAIN && lx) state_n = IDLE;
`endif
    done_n = fin || zstart;
    busy_n = state_n != IDLE || fin;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      done <= 1'b0;
      busy <= 1'b0;
      mem_addr <= '0;
      rem <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      pend_addr <= '0;
      occ <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      a0 <= '0;
      a1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
`ifdef MEM_SCAN_CHECKSUM_EN
      acc <= '0;
`endif
    end else begin
      state <= state_n;
      done <= done_n;
      busy <= busy_n;
      if (state == IDLE && start && count != '0) begin
        mem_addr <= base_addr;
        rem <= count;
`ifdef MEM_SCAN_CHECKSUM_EN
        acc <= '0;
`endif
      end
      if (mem_rd_en) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        rem <= rem - (ADDR_W+1)'(1);
        pend_addr <= mem_addr;
        pend_last <= rem == (ADDR_W+1)'(1);
      end
      pend <= mem_rd_en;
`ifdef MEM_SCAN_CHECKSUM_EN
      if (pend) acc <= acc + mem_rdata;
`endif
      if (shift) begin
        d0 <= d1;
        a0 <= a1;
        l0 <= l1;
      end
      if (push && occ == (shift ? 2'd2 : 2'd1)) begin
        d1 <= mem_rdata;
        a1 <= pend_addr;
        l1 <= pend_last;
      end else if (push) begin
        d0 <= mem_rdata;
        a0 <= pend_addr;
        l0 <= pend_last;
      end
      occ <= occ - {1'b0, shift} + {1'b0, push};
    end
  end
endmodule

// File: tb/tb_mem_scan_reader.sv
// tb_mem_scan_reader: scoreboard bench for mem_scan_reader with a mem[i]=i*3 memory model.
module tb_mem_scan_reader;
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [7:0] base_addr;
  logic [8:0] count;
  logic busy, done, mem_rd_en, out_valid, out_last;
  logic [7:0] mem_addr, out_addr;
  logic [31:0] mem_rdata, out_data;
  typedef struct packed {logic [7:0] a; logic [31:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  logic [7:0] rd_q[$];
  int passed = 0, total = 0;
  int r_first, r_done, r_last, r_done_cnt, r_busy_err, r_stab_err, r_over_err, r_beats;

  mem_scan_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= {24'b0, mem_addr} * 32'd3;

  task automatic expect_scan(input logic [7:0] b, input int n);
    logic [31:0] sum = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] a = b + 8'(i);
`ifdef MEM_SCAN_CHECKSUM_EN
      exp_q.push_back('{a, {24'b0, a} * 32'd3, 1'b0});
`else
      exp_q.push_back('{a, {24'b0, a} * 32'd3, i == n - 1});
`endif
      sum += {24'b0, a} * 32'd3;
    end
`ifdef MEM_SCAN_CHECKSUM_EN
    if (n > 0) exp_q.push_back('{8'h00, sum, 1'b1});
`endif
  endtask

  task automatic kick(input logic [7:0] b, input int n);
    @(negedge clk);
    base_addr = b;
    count = 9'(n);
    start = 1'b1;
    expect_scan(b, n);
  endtask

  task automatic collect(input int max_c, input int pat, input bit zero, input int restart_c);
    bit held = 0, xfer;
    beat_t h, e;
    int outst = 0;
    r_first = -1; r_done = -1; r_last = -1; r_done_cnt = 0;
    r_busy_err = 0; r_stab_err = 0; r_over_err = 0; r_beats = 0;
    rd_q.delete();
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      start = c == restart_c;
      if (c == restart_c) begin
        base_addr = 8'd100;
        count = 9'd5;
      end
      out_ready = pat == 0 ? 1'b1 : ((c - 1) % 4 == 0 || (c - 1) % 4 == 3);
      #1;
      xfer = out_valid && out_ready;
      if (mem_rd_en) begin
        rd_q.push_back(mem_addr);
        if (outst - int'(xfer) >= 2) r_over_err++;
      end
      if (held && (out_valid !== 1'b1 || {out_addr, out_data, out_last} !== h)) r_stab_err++;
      held = out_valid && !out_ready;
      h = '{out_addr, out_data, out_last};
      if (out_valid && r_first < 0) r_first = c;
      if (done) begin
        r_done_cnt++;
        if (r_done < 0) r_done = c;
      end
      if (busy !== (zero ? 1'b0 : (r_done < 0 || r_done == c))) r_busy_err++;
      if (xfer) begin
        r_beats++;
        r_last = c;
        total++;
        if (exp_q.size() == 0) $display("FAIL beat_extra: got a=%0h d=%0h l=%0b, expected no beat", out_addr, out_data, out_last);
        else begin
          e = exp_q.pop_front();
          if ({out_addr, out_data, out_last} !== e)
            $display("FAIL beat: got a=%0h d=%0h l=%0b, expected a=%0h d=%0h l=%0b", out_addr, out_data, out_last, e.a, e.d, e.l);
          else passed++;
        end
      end
      outst += int'(mem_rd_en) - int'(xfer);
      if (r_done > 0 && c >= r_done + 2) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_data} !== '0)
      $display("FAIL reset_outputs: got %0h, expected 0", {busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_data});
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_basic;
    kick(8'd4, 3);
    collect(40, 0, 0, 0);
    total++; if (r_first !== 2) $display("FAIL basic_first_valid: got %0d, expected 2", r_first); else passed++;
    total++; if (r_done !== r_last + 1) $display("FAIL basic_done_cycle: got %0d, expected %0d", r_done, r_last + 1); else passed++;
    total++; if (r_done_cnt !== 1) $display("FAIL basic_done_count: got %0d, expected 1", r_done_cnt); else passed++;
    total++; if (rd_q.size() !== 3) $display("FAIL basic_reads: got %0d, expected 3", rd_q.size()); else passed++;
    total++; if (r_busy_err !== 0) $display("FAIL basic_busy: got %0d errors, expected 0", r_busy_err); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL basic_missing: got %0d left, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_zero;
    kick(8'd9, 0);
    collect(10, 0, 1, 0);
    total++; if (rd_q.size() !== 0) $display("FAIL zero_reads: got %0d, expected 0", rd_q.size()); else passed++;
    total++; if (r_first !== -1) $display("FAIL zero_valid: got %0d, expected -1", r_first); else passed++;
    total++; if (r_done !== 1) $display("FAIL zero_done_cycle: got %0d, expected 1", r_done); else passed++;
    total++; if (r_busy_err !== 0) $display("FAIL zero_busy: got %0d errors, expected 0", r_busy_err); else passed++;
  endtask

  task automatic test_wrap;
    logic [7:0] wa [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    kick(8'hFE, 4);
    collect(40, 0, 0, 0);
    total++; if (rd_q.size() !== 4) $display("FAIL wrap_reads: got %0d, expected 4", rd_q.size()); else passed++;
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== wa[i]) $display("FAIL wrap_addr%0d: got %0h, expected %0h", i, rd_q[i], wa[i]); else passed++;
    end
    total++; if (exp_q.size() !== 0) $display("FAIL wrap_missing: got %0d left, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_stall;
    kick(8'd10, 8);
    collect(80, 1, 0, 0);
    total++; if (r_stab_err !== 0) $display("FAIL stall_stable: got %0d errors, expected 0", r_stab_err); else passed++;
    total++; if (r_over_err !== 0) $display("FAIL stall_overfill: got %0d errors, expected 0", r_over_err); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL stall_missing: got %0d left, expected 0", exp_q.size()); else passed++;
    total++; if (r_done !== r_last + 1) $display("FAIL stall_done_cycle: got %0d, expected %0d", r_done, r_last + 1); else passed++;
  endtask

  task automatic test_reset_mid;
    kick(8'd0, 10);
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    total++; if (!(out_valid === 1'b1 && out_addr === 8'd2)) $display("FAIL mid_third_beat: got v=%0b a=%0h, expected v=1 a=2", out_valid, out_addr); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_data} !== '0)
      $display("FAIL mid_reset_outputs: got %0h, expected 0", {busy, done, mem_rd_en, out_valid, out_last, mem_addr, out_addr, out_data});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, done, busy} !== 3'b000) $display("FAIL mid_after_reset: got %0b, expected 000", {out_valid, done, busy}); else passed++;
    exp_q.delete();
    kick(8'd7, 2);
    collect(40, 0, 0, 0);
    total++; if (exp_q.size() !== 0) $display("FAIL mid_rescan_missing: got %0d left, expected 0", exp_q.size()); else passed++;
    total++; if (r_done_cnt !== 1) $display("FAIL mid_rescan_done: got %0d, expected 1", r_done_cnt); else passed++;
  endtask

  task automatic test_restart;
    kick(8'd20, 4);
    collect(40, 0, 0, 2);
    total++; if (rd_q.size() !== 4) $display("FAIL restart_reads: got %0d, expected 4", rd_q.size()); else passed++;
    total++; if (rd_q.size() > 0 && rd_q[0] !== 8'd20) $display("FAIL restart_base: got %0h, expected 14", rd_q[0]); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL restart_missing: got %0d left, expected 0", exp_q.size()); else passed++;
    total++; if (r_done_cnt !== 1) $display("FAIL restart_done: got %0d, expected 1", r_done_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_wrap;
    test_stall;
    test_reset_mid;
    test_restart;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_scan_reader.md
MEM_SCAN_READER -- requirements
Module: mem_scan_reader

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  begin scan; sampled in IDLE only.
REQ-006 base_addr  in  ADDR_W  first word address; captured on accepted start.
REQ-007 count  in  ADDR_W+1  words to read, 0..2^ADDR_W; captured on accepted start.
REQ-008 busy  out  1  high from the cycle after accepted start until the cycle done is high, inclusive.
REQ-009 done  out  1  one-cycle pulse on scan completion.
REQ-010 mem_rd_en  out  1  memory read strobe.
REQ-011 mem_addr  out  ADDR_W  memory read address; valid with mem_rd_en.
REQ-012 mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-013 out_valid  out  1  output beat valid.
REQ-014 out_ready  in  1  sink accepts beat; transfer when out_valid and out_ready are both high.
REQ-015 out_addr  out  ADDR_W  address of the word in out_data.
REQ-016 out_data  out  DATA_W  word read from memory.
REQ-017 out_last  out  1  marks the final beat of the scan.

Function
REQ-018 FSM states: IDLE, READ, DRAIN; with CHECKSUM_EN, adds SUM.
REQ-019 IDLE->READ on start with count!=0; IDLE->IDLE with done pulse next cycle on start with count==0, no mem_rd_en, no beats.
REQ-020 READ issues one mem_rd_en per cycle at most; addresses base_addr+i for i=0..count-1, modulo 2^ADDR_W (wrap from max to 0).
REQ-021 Returned words enter a 2-entry output buffer; mem_rd_en asserted only when buffered entries plus in-flight reads < 2; no word is ever dropped or duplicated.
REQ-022 READ->DRAIN in the cycle the final read is issued; DRAIN->IDLE (or ->SUM) when the buffer is empty and nothing is in flight.
REQ-023 Beats emitted in address-issue order; out_addr/out_data/out_last held stable while out_valid high and out_ready low.
REQ-024 With out_ready held high and no checksum, throughput is one beat per cycle; first beat out_valid 2 cycles after start accepted.
REQ-025 done pulses in the cycle after the last beat transfers; busy falls with done.
REQ-026 start while busy is ignored; base_addr/count changes after capture have no effect.

Reset
REQ-027 rst low at a rising edge: state=IDLE, buffer and in-flight flags cleared, busy=0, done=0, mem_rd_en=0, out_valid=0, out_last=0, mem_addr=0, out_addr=0, out_data=0, checksum accumulator=0.
REQ-028 Reset mid-scan aborts immediately; no done pulse; read data returning the cycle after reset is discarded.

Configuration
REQ-029 Macro MEM_SCAN_CHECKSUM_EN defined: after last data beat, one extra beat in state SUM with out_data = sum of all data words mod 2^DATA_W, out_addr=0, out_last=1 on this beat only; count==0 still emits no beats.
REQ-030 MEM_SCAN_CHECKSUM_EN undefined: no SUM state, no accumulator; out_last=1 on the final data beat.

Verification
REQ-031 Memory mem[i]=i*3; start, base_addr=4, count=3, out_ready=1 -> beats (4,12),(5,15),(6,18); last on (6,18); done one cycle later; checksum build adds beat (0,45,last).
REQ-032 count=0 start -> no mem_rd_en, no out_valid, done pulse next cycle, busy stays 0.
REQ-033 ADDR_W=8, base_addr=0xFE, count=4 -> mem_addr sequence 0xFE,0xFF,0x00,0x01.
REQ-034 count=8, out_ready toggles 1,0,0,1 repeating -> all 8 words delivered in order, outputs stable while stalled, mem_rd_en never issued with 2 entries occupied.
REQ-035 rst low during 3rd beat of count=10 scan -> all outputs zero next cycle, no done; new start with count=2 completes correctly.
REQ-036 start pulsed again while busy with different base_addr -> ignored; original scan completes unchanged.
